// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the clocked ALU with iterative multiply/divide.
//   - opcode constants for the 4-bit control field
//   - FSM state encoding for the multi-cycle sequencer
//   - helpers that classify an opcode (multi-cycle, divide, signed)
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_MULT  = 4'b1001;
  localparam logic [3:0] ALU_DIVU  = 4'b1010;
  localparam logic [3:0] ALU_DIV   = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MFHI  = 4'b1101;
  localparam logic [3:0] ALU_MFLO  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Multiply/divide occupy the 10xx corner of the opcode space; everything
  // else (including undefined codes) completes in a single cycle.
  function automatic logic is_multi_cycle(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  // Within the 10xx group, bit 1 selects divide and bit 0 selects signed.
  function automatic logic is_div_op(input logic [3:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// -----------------------------------------------------------------------------
// alu_mdu_iter
// Shared shift datapath for iterative multiply and restoring divide.
// Operands are converted to magnitudes on load, one bit is processed per
// step, and the sign-corrected HI/LO pair is presented combinationally for
// the parent to capture during its FIX cycle.
// Ports:
//   clock, reset_n   : clock and asynchronous active-low reset
//   load             : latch operands and mode, restart the iteration counter
//   step             : perform one multiply/divide iteration
//   is_div, is_signed: operation mode, sampled with load
//   a, b             : operands, sampled with load
//   last             : the iteration counter is at zero (final step)
//   hi_out, lo_out   : sign-corrected upper/lower results
// -----------------------------------------------------------------------------
module alu_mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   a_keep;
  logic [CW-1:0]      count;
  logic               div_mode;
  logic               sign_a;
  logic               sign_diff;
  logic               b_zero;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // Magnitudes of the incoming operands. The most negative value maps onto
  // itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  // One iteration. Multiply: the accumulator holds {partial, multiplier};
  // add the multiplicand into the upper half when the low bit is set, then
  // shift right. Divide: the accumulator holds {remainder, dividend}; shift
  // the next dividend bit into the remainder, trial-subtract the divisor and
  // keep the difference only when it does not go negative.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_shift - {1'b0, opb};
    if (div_mode) begin
      if (rem_diff[WIDTH]) begin
        acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Operand latch, accumulator and down-counter. The counter starts at
  // WIDTH-1 so that the step taken while it reads zero is the last one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      opb       <= '0;
      a_keep    <= '0;
      count     <= '0;
      div_mode  <= 1'b0;
      sign_a    <= 1'b0;
      sign_diff <= 1'b0;
      b_zero    <= 1'b0;
    end else if (load) begin
      acc       <= {{WIDTH{1'b0}}, a_mag};
      opb       <= b_mag;
      a_keep    <= a;
      count     <= CW'(WIDTH - 1);
      div_mode  <= is_div;
      sign_a    <= is_signed & a[WIDTH-1];
      sign_diff <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      b_zero    <= (b == '0);
    end else if (step) begin
      acc       <= acc_next;
      count     <= count - CW'(1);
    end
  end

  assign last = (count == '0);

  // Sign correction applied to the finished magnitudes. The quotient is
  // negated when the operand signs differ (truncation toward zero), the
  // remainder follows the dividend. A zero divisor bypasses the datapath
  // and returns the original dividend with an all-ones quotient.
  always_comb begin
    prod = sign_diff ? -acc : acc;
    quot = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (div_mode) begin
      if (b_zero) begin
        hi_out = a_keep;
        lo_out = '1;
      end else begin
        hi_out = sign_a ? -rem : rem;
        lo_out = sign_diff ? -quot : quot;
      end
    end else begin
      hi_out = prod[2*WIDTH-1:WIDTH];
      lo_out = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu
// Clocked EX-stage ALU. Logic/arithmetic/compare ops and HI/LO reads finish
// in one cycle into the result register; multiply and divide run through
// the iterative datapath and write the HI/LO pair. The pipeline stalls
// while busy is high.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : operation request, honoured only while not busy
//   control        : 4-bit opcode, sampled with start
//   a, b           : operands, sampled with start
//   result, zero   : result register and its zero flag
//   busy           : multi-cycle operation in flight
//   done           : one-cycle completion pulse
//   hi, lo         : HI/LO registers
// -----------------------------------------------------------------------------
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import alu_pkg::*;

  state_t           state;
  state_t           state_next;
  logic             accept_single;
  logic             load_en;
  logic             calc_en;
  logic             fix_en;
  logic             single_done;
  logic             alu_write;
  logic [WIDTH-1:0] alu_value;
  logic             iter_last;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  // Requests are only seen in IDLE; while busy they are dropped.
  assign accept_single = start && (state == IDLE) && !is_multi_cycle(control);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the multi-cycle sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && is_multi_cycle(control)) state_next = CALC;
      CALC: if (iter_last) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sequencer outputs. done covers both the single-cycle pulse and the
  // DONE state of a multiply/divide.
  always_comb begin
    busy    = (state != IDLE);
    load_en = (state == IDLE) && start && is_multi_cycle(control);
    calc_en = (state == CALC);
    fix_en  = (state == FIX);
    done    = (state == DONE) || single_done;
  end

  // Single-cycle operation values. Undefined codes leave result untouched.
  always_comb begin
    alu_value = result;
    alu_write = 1'b1;
    case (control)
      ALU_AND:  alu_value = a & b;
      ALU_OR:   alu_value = a | b;
      ALU_ADD:  alu_value = a + b;
      ALU_SUB:  alu_value = a - b;
      ALU_NOR:  alu_value = ~(a | b);
      ALU_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_value = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_MFHI: alu_value = hi;
      ALU_MFLO: alu_value = lo;
      default:  alu_write = 1'b0;
    endcase
  end

  // Result register and the single-cycle completion pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result      <= '0;
      single_done <= 1'b0;
    end else begin
      single_done <= accept_single;
      if (accept_single && alu_write) begin
        result <= alu_value;
      end
    end
  end

  // HI/LO are written only at the end of FIX, so an abort leaves them alone
  // until reset clears them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (fix_en) begin
      hi <= iter_hi;
      lo <= iter_lo;
    end
  end

  assign zero = (result == '0);

  alu_mdu_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load_en),
    .step     (calc_en),
    .is_div   (is_div_op(control)),
    .is_signed(is_signed_op(control)),
    .a        (a),
    .b        (b),
    .last     (iter_last),
    .hi_out   (iter_hi),
    .lo_out   (iter_lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu
// Directed and randomized bench for alu_mdu at WIDTH=32. Expected values come
// from a behavioural model using 64-bit integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_mdu;

  localparam int W = 32;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [3:0]   control;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;
  logic [W-1:0] m_result;

  logic [W-1:0] corners [5];

  alu_mdu #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .control(control),
    .a      (a),
    .b      (b),
    .result (result),
    .zero   (zero),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net in case something stalls the sequence.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the architectural
  // HI/LO/result state.
  function automatic void modelOp(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    longint sx;
    longint sy;
    longint q;
    longint r;
    sx = $signed(x);
    sy = $signed(y);
    case (op)
      4'b0000: m_result = x & y;
      4'b0001: m_result = x | y;
      4'b0010: m_result = x + y;
      4'b0110: m_result = x - y;
      4'b1100: m_result = ~(x | y);
      4'b0111: m_result = (sx < sy) ? 32'd1 : 32'd0;
      4'b0011: m_result = (x < y) ? 32'd1 : 32'd0;
      4'b1101: m_result = m_hi;
      4'b1110: m_result = m_lo;
      4'b1000: begin
        p = {32'd0, x} * {32'd0, y};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      4'b1001: begin
        p = sx * sy;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      4'b1010: begin
        if (y == 0) begin
          m_hi = x;
          m_lo = '1;
        end else begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
      4'b1011: begin
        if (y == 0) begin
          m_hi = x;
          m_lo = '1;
        end else begin
          q = sx / sy;
          r = sx % sy;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  // Issues one operation and checks it against the model. Single-cycle ops
  // are checked right after their sampling edge; keep leaves start asserted
  // so the next call issues back-to-back. Multi-cycle ops are timed edge by
  // edge up to the done pulse and the busy release.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input bit keep);
    int  lat;
    bit  found;
    @(negedge clock);
    start   = 1'b1;
    control = op;
    a       = x;
    b       = y;
    @(posedge clock);
    #1;
    if (op[3:2] == 2'b10) begin
      checkOutput("busy_rise", 32'(busy), 32'd1);
      @(negedge clock);
      start = 1'b0;
      lat   = 0;
      found = 0;
      for (int k = 1; k <= W + 6 && !found; k++) begin
        @(posedge clock);
        #1;
        if (done) begin
          lat   = k;
          found = 1;
        end
      end
      modelOp(op, x, y);
      checkOutput("md_done_latency", 32'(lat), 32'(W + 1));
      checkOutput("md_hi", hi, m_hi);
      checkOutput("md_lo", lo, m_lo);
      checkOutput("md_result_kept", result, m_result);
      checkOutput("md_busy_in_done", 32'(busy), 32'd1);
      @(posedge clock);
      #1;
      checkOutput("md_done_drop", 32'(done), 32'd0);
      checkOutput("md_busy_fall", 32'(busy), 32'd0);
    end else begin
      modelOp(op, x, y);
      checkOutput("sc_done", 32'(done), 32'd1);
      checkOutput("sc_busy", 32'(busy), 32'd0);
      checkOutput("sc_result", result, m_result);
      checkOutput("sc_zero", 32'(zero), 32'(m_result == 32'd0));
      checkOutput("sc_hi", hi, m_hi);
      checkOutput("sc_lo", lo, m_lo);
      if (!keep) begin
        @(negedge clock);
        start = 1'b0;
      end
    end
  endtask

  function automatic logic [W-1:0] pickOperand();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int pulses;
    logic [3:0] rop;

    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;

    m_hi = '0;
    m_lo = '0;
    m_result = '0;

    start   = 1'b0;
    control = 4'd0;
    a       = '0;
    b       = '0;
    reset_n = 1'b0;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // ADD wraps to zero.
    applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
    checkOutput("add_wrap_const", result, 32'd0);
    checkOutput("add_wrap_zero", 32'(zero), 32'd1);

    // SLT then SLTU back-to-back; each call checks done after its own edge.
    applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'd1, 1);
    checkOutput("slt_const", result, 32'd1);
    applyStimulus(4'b0011, 32'hFFFF_FFFF, 32'd1, 0);
    checkOutput("sltu_const", result, 32'd0);

    // Signed and unsigned multiply, then read LO.
    applyStimulus(4'b1001, 32'hFFFF_FFFF, 32'd2, 0);
    checkOutput("mult_hi_const", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo_const", lo, 32'hFFFF_FFFE);
    applyStimulus(4'b1000, 32'hFFFF_FFFF, 32'd2, 0);
    checkOutput("multu_hi_const", hi, 32'h0000_0001);
    checkOutput("multu_lo_const", lo, 32'hFFFF_FFFE);
    applyStimulus(4'b1110, 32'd0, 32'd0, 0);
    checkOutput("mflo_const", result, 32'hFFFF_FFFE);

    // Signed divide, divide by zero, overflow case.
    applyStimulus(4'b1011, 32'hFFFF_FFF9, 32'd2, 0);
    checkOutput("div_lo_const", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi_const", hi, 32'hFFFF_FFFF);
    applyStimulus(4'b1010, 32'd5, 32'd0, 0);
    checkOutput("divu0_hi_const", hi, 32'd5);
    checkOutput("divu0_lo_const", lo, 32'hFFFF_FFFF);
    applyStimulus(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    checkOutput("divmin_lo_const", lo, 32'h8000_0000);
    checkOutput("divmin_hi_const", hi, 32'd0);

    // A start during a multiply must be dropped.
    @(negedge clock);
    start = 1'b1; control = 4'b1000; a = 32'd3; b = 32'd4;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    start = 1'b1; control = 4'b0010; a = 32'd1; b = 32'd1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < W + 8; k++) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    modelOp(4'b1000, 32'd3, 32'd4);
    checkOutput("busy_ignore_pulses", 32'(pulses), 32'd1);
    checkOutput("busy_ignore_result", result, m_result);
    checkOutput("busy_ignore_lo", lo, 32'd12);
    checkOutput("busy_ignore_hi", hi, 32'd0);

    // Abort a divide with reset.
    @(negedge clock);
    start = 1'b1; control = 4'b1010; a = 32'd100; b = 32'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    checkOutput("abort_result", result, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    m_result = '0;
    pulses = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clock);
      #1;
      if (done || busy) pulses++;
    end
    checkOutput("abort_no_done", 32'(pulses), 32'd0);
    checkOutput("abort_lo_kept", lo, 32'd0);
    applyStimulus(4'b1010, 32'd100, 32'd7, 0);
    checkOutput("divu_lo_const", lo, 32'd14);
    checkOutput("divu_hi_const", hi, 32'd2);

    // Randomized mix over all sixteen codes, including undefined ones.
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      applyStimulus(rop, pickOperand(), pickOperand(), bit'($urandom_range(0, 1)));
    end
    @(negedge clock);
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
